// File: rtl/conv1_layer1_pkg.sv
// Shared definitions for the conv1 layer1 dense accumulate stage.
//   - lane geometry of the product vector (N_LANE lanes of DW bits, FRAC
//     fractional bits)
//   - adder-tree stage widths
//   - FSM state encoding
//   - sat16: clip a wide signed sum to 16 bits and report clipping
package conv1_layer1_pkg;

  localparam int N_LANE = 25;
  localparam int DW     = 16;
  localparam int FRAC   = 8;

  // Tree shape: 5 partial sums of 5 lanes, then a 5-to-1 sum.
  localparam int N_PART   = 5;
  localparam int PART_LEN = 5;
  localparam int S1_W     = 19;  // 5 x 16-bit needs 3 extra bits
  localparam int S2_W     = 21;  // 25 x 16-bit needs 5 extra bits

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DW-1:0] val;
    logic          clipped;
  } sat_t;

  // Clip to [-32768, 32767]; clipped=1 when the input was outside range.
  function automatic sat_t sat16(input logic signed [31:0] x);
    sat_t r;
    if (x > 32'sd32767) begin
      r.val     = 16'h7FFF;
      r.clipped = 1'b1;
    end else if (x < -32'sd32768) begin
      r.val     = 16'h8000;
      r.clipped = 1'b1;
    end else begin
      r.val     = x[15:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv1_layer1_add_tree.sv
// Two-stage registered reduction of the 25-lane product vector.
//   clk      clock
//   rst      synchronous active-low reset, clears valids and data
//   clr      synchronous flush of the valid bits (run restart)
//   in_v     input beat valid
//   in_data  25 x 16-bit signed lanes, lane i at [16i+15:16i]
//   out_v    valid of out_sum, 2 cycles after in_v
//   out_sum  21-bit signed sum of all 25 lanes
module conv1_layer1_add_tree
  import conv1_layer1_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_v,
  input  logic [N_LANE*DW-1:0]   in_data,
  output logic                   out_v,
  output logic signed [S2_W-1:0] out_sum
);

  logic                   s1_v;
  logic signed [S1_W-1:0] s1_sum  [N_PART];
  logic signed [S1_W-1:0] s1_next [N_PART];
  logic signed [S2_W-1:0] s2_next;

  // Stage 1: each partial sum covers PART_LEN consecutive lanes.
  always_comb begin
    for (int p = 0; p < N_PART; p++) begin
      s1_next[p] = '0;
      for (int l = 0; l < PART_LEN; l++) begin
        s1_next[p] = s1_next[p] +
                     S1_W'($signed(in_data[DW*(PART_LEN*p + l) +: DW]));
      end
    end
  end

  // Stage 2: fold the partial sums.
  always_comb begin
    s2_next = '0;
    for (int p = 0; p < N_PART; p++) begin
      s2_next = s2_next + S2_W'(s1_sum[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      out_v   <= 1'b0;
      out_sum <= '0;
      for (int p = 0; p < N_PART; p++) s1_sum[p] <= '0;
    end else begin
      s1_v  <= in_v && !clr;
      out_v <= s1_v && !clr;
      if (in_v) begin
        for (int p = 0; p < N_PART; p++) s1_sum[p] <= s1_next[p];
      end
      if (s1_v) out_sum <= s2_next;
    end
  end

endmodule

// File: rtl/conv1_layer1_dense_accum.sv
// Reduces each product beat to a scalar, accumulates ACC_LEN beats per output
// element and emits a saturated 16-bit result, N_GROUP results per start.
//   clk        clock
//   rst        synchronous active-low reset
//   start      one-cycle pulse, begins (or restarts) a run
//   mult_res_v product beat valid
//   mult_res   25 x 16-bit signed lanes
//   acc_res    saturated result, held between pulses
//   acc_res_v  one-cycle pulse, acc_res valid
//   sat        pulses with acc_res_v when the result was clipped
//   busy       high from start until done
//   done       one-cycle pulse after the last acc_res_v
//   state_dbg  current FSM state (IDLE/RUN/DRAIN/DONE encoding)
//
// Handshake: every *_v signal is a one-cycle qualifier with no ready; data
// is consumed in the cycle its valid is high and there is no backpressure.
module conv1_layer1_dense_accum
  import conv1_layer1_pkg::*;
#(
  parameter int ACC_LEN = 4,
  parameter int N_GROUP = 8,
  parameter int ACC_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mult_res_v,
  input  logic [N_LANE*DW-1:0] mult_res,
  output logic [DW-1:0]        acc_res,
  output logic                 acc_res_v,
  output logic                 sat,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int TOTAL = ACC_LEN * N_GROUP;
  localparam int BW    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int GW    = (N_GROUP > 1) ? $clog2(N_GROUP) : 1;
  localparam int IW    = $clog2(TOTAL + 1);

  state_e                  state;
  logic                    accept;
  logic                    tree_v;
  logic signed [S2_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_full;
  sat_t                    sr;
  logic [BW-1:0]           beat_cnt;
  logic [GW-1:0]           grp_cnt;
  logic [IW-1:0]           in_cnt;
  logic                    last_v;   // the acc_res_v being issued is the run's last

  // A beat coinciding with start belongs to neither run and is dropped.
  assign accept    = mult_res_v && (state == RUN) && !start;
  assign state_dbg = state;

  conv1_layer1_add_tree u_tree (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .in_v    (accept),
    .in_data (mult_res),
    .out_v   (tree_v),
    .out_sum (tree_sum)
  );

  assign sum_full = acc + ACC_W'(tree_sum);
  assign sr       = sat16(32'(sum_full));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      grp_cnt   <= '0;
      in_cnt    <= '0;
      last_v    <= 1'b0;
      acc_res   <= '0;
      acc_res_v <= 1'b0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      // Restart from any state; tree valids are flushed through clr.
      state     <= RUN;
      acc       <= '0;
      beat_cnt  <= '0;
      grp_cnt   <= '0;
      in_cnt    <= '0;
      last_v    <= 1'b0;
      acc_res_v <= 1'b0;
      sat       <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      acc_res_v <= 1'b0;
      sat       <= 1'b0;
      done      <= 1'b0;
      last_v    <= 1'b0;

      // Accumulate at tree output; the closing beat of a group emits the
      // result and reloads zero so a back-to-back group starts clean.
      if (tree_v) begin
        if (beat_cnt == BW'(ACC_LEN - 1)) begin
          acc_res   <= sr.val;
          acc_res_v <= 1'b1;
          sat       <= sr.clipped;
          acc       <= '0;
          beat_cnt  <= '0;
          last_v    <= (grp_cnt == GW'(N_GROUP - 1));
          grp_cnt   <= (grp_cnt == GW'(N_GROUP - 1)) ? '0 : grp_cnt + 1'b1;
        end else begin
          acc      <= sum_full;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: ;
        RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == IW'(TOTAL - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_v) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_layer1_dense_accum.sv
// Bench for conv1_layer1_dense_accum with ACC_LEN=4, N_GROUP=2.
// A run-level model predicts, per accepted beat, the group sums and the
// cycles at which results, done and busy must appear; one compare process
// checks every cycle, and each directed test pins its results to literals.
module tb_conv1_layer1_dense_accum;
  import conv1_layer1_pkg::*;

  localparam int ACC_LEN = 4;
  localparam int N_GROUP = 2;
  localparam int TOTAL   = ACC_LEN * N_GROUP;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mult_res_v;
  logic [399:0] mult_res;
  logic [15:0]  acc_res;
  logic         acc_res_v;
  logic         sat;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  conv1_layer1_dense_accum #(
    .ACC_LEN (ACC_LEN),
    .N_GROUP (N_GROUP),
    .ACC_W   (32)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mult_res_v (mult_res_v),
    .mult_res   (mult_res),
    .acc_res    (acc_res),
    .acc_res_v  (acc_res_v),
    .sat        (sat),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit          in_run    = 1'b0;
  int          n_acc     = 0;
  longint      grp_sum   = 0;
  logic [16:0] exp_q[$];          // {sat, value}
  int          exp_cyc_q[$];      // cycle the result must be visible
  int          done_cyc  = -1;
  bit          busy_exp  = 1'b0;
  logic [15:0] hold_exp  = '0;
  int          last_beat_cyc = -1;

  // Observations for the literal checks.
  logic [16:0] got_q[$];
  int          got_cyc_q[$];
  int          seen_done_cyc = -1;

  function automatic int lane_sum(input logic [399:0] v);
    int s = 0;
    for (int i = 0; i < 25; i++) s += int'($signed(v[16*i +: 16]));
    return s;
  endfunction

  function automatic logic [16:0] clip(input longint s);
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  function automatic logic [399:0] make_vec(input logic [15:0] l0, input logic [15:0] l1,
                                            input logic [15:0] l2, input logic [15:0] rest);
    logic [399:0] v;
    for (int i = 0; i < 25; i++) v[16*i +: 16] = rest;
    v[15:0]  = l0;
    v[31:16] = l1;
    v[47:32] = l2;
    return v;
  endfunction

  task automatic model_step();
    if (!rst) begin
      in_run   = 1'b0;
      n_acc    = 0;
      grp_sum  = 0;
      exp_q.delete();
      exp_cyc_q.delete();
      done_cyc = -1;
      busy_exp = 1'b0;
      hold_exp = '0;
    end else if (start) begin
      in_run   = 1'b1;
      n_acc    = 0;
      grp_sum  = 0;
      exp_q.delete();
      exp_cyc_q.delete();
      done_cyc = -1;
      busy_exp = 1'b1;
    end else begin
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_exp = 1'b0;
      if (in_run && mult_res_v) begin
        n_acc++;
        grp_sum += lane_sum(mult_res);
        if (n_acc % ACC_LEN == 0) begin
          exp_q.push_back(clip(grp_sum));
          exp_cyc_q.push_back(cyc + 2);
          grp_sum = 0;
        end
        if (n_acc == TOTAL) begin
          in_run        = 1'b0;
          done_cyc      = cyc + 3;
          last_beat_cyc = cyc;
        end
      end
    end
  endtask

  task automatic compare_step();
    bit          exp_v;
    logic [16:0] e;
    exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    e     = '0;
    if (exp_v) begin
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      hold_exp = e[15:0];
    end
    check("acc_res_v", 32'(acc_res_v), 32'(exp_v));
    check("acc_res",   32'(acc_res),   32'(hold_exp));
    check("sat",       32'(sat),       32'(e[16]));
    check("done",      32'(done),      32'(cyc == done_cyc));
    check("busy",      32'(busy),      32'(busy_exp));
    check("state_idle", 32'(state_dbg == 2'd0), 32'(!busy_exp));
    if (acc_res_v) begin
      got_q.push_back({sat, acc_res});
      got_cyc_q.push_back(cyc);
    end
    if (done) seen_done_cyc = cyc;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #2;
      compare_step();
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic s, input logic v, input logic [399:0] d);
    @(negedge clk);
    start      = s;
    mult_res_v = v;
    mult_res   = d;
  endtask

  task automatic beats(input int n, input logic [399:0] d, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, d);
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, '0);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    drive(1'b0, 1'b0, '0);
    while (busy && k < 100) begin
      drive(1'b0, 1'b0, '0);
      k++;
    end
    check({name, "_idle_timeout"}, 32'(k < 100), 32'(1));
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic expect_pair(input string name, input logic [16:0] e0, input logic [16:0] e1);
    check({name, "_count"}, 32'(got_q.size()), 32'(2));
    if (got_q.size() > 0) check({name, "_res0"}, 32'(got_q[0]), 32'(e0));
    if (got_q.size() > 1) check({name, "_res1"}, 32'(got_q[1]), 32'(e1));
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [399:0] all_100, all_7fff, all_8000, lane0_5, cancel_v, mixed_v;

  initial begin
    all_100  = make_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    all_7fff = make_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    all_8000 = make_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    lane0_5  = make_vec(16'h0005, 16'h0000, 16'h0000, 16'h0000);
    cancel_v = make_vec(16'hFFFF, 16'h0001, 16'h0000, 16'h0000);
    mixed_v  = make_vec(16'h0100, 16'hFF00, 16'h0003, 16'h0000);

    rst        = 1'b0;
    start      = 1'b0;
    mult_res_v = 1'b0;
    mult_res   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_acc_res", 32'(acc_res), 32'h0);
    check("reset_busy",    32'(busy),    32'h0);

    // Beats in IDLE are ignored.
    beats(3, all_100, 0);
    drive(1'b0, 1'b0, '0);
    repeat (4) drive(1'b0, 1'b0, '0);
    check("idle_beats_no_out", 32'(got_q.size()), 32'(0));

    // All lanes 0x0100, back-to-back: 25*256*4 = 0x6400 per group.
    drive(1'b1, 1'b0, '0);
    beats(TOTAL, all_100, 0);
    wait_idle("t_unity");
    check("t_unity_lat", 32'(got_cyc_q[1] - last_beat_cyc), 32'(2));
    check("t_unity_done_lat", 32'(seen_done_cyc - got_cyc_q[1]), 32'(1));
    expect_pair("t_unity", {1'b0, 16'h6400}, {1'b0, 16'h6400});

    // Lane 0 = 5 with 2-cycle gaps: 5*4 = 0x0014 per group.
    drive(1'b1, 1'b0, '0);
    beats(TOTAL, lane0_5, 2);
    wait_idle("t_gap");
    expect_pair("t_gap", {1'b0, 16'h0014}, {1'b0, 16'h0014});

    // Saturation both ways, back-to-back groups.
    drive(1'b1, 1'b0, '0);
    beats(ACC_LEN, all_7fff, 0);
    beats(ACC_LEN, all_8000, 0);
    wait_idle("t_sat");
    expect_pair("t_sat", {1'b1, 16'h7FFF}, {1'b1, 16'h8000});

    // Cancelling lanes -> 0; mixed signs 256-256+3 = 3 per beat -> 0x000C.
    drive(1'b1, 1'b0, '0);
    beats(ACC_LEN, cancel_v, 0);
    beats(ACC_LEN, mixed_v, 0);
    wait_idle("t_sign");
    expect_pair("t_sign", {1'b0, 16'h0000}, {1'b0, 16'h000C});

    // Reset mid-group aborts; the next run is clean.
    drive(1'b1, 1'b0, '0);
    beats(2, all_7fff, 0);
    @(negedge clk);
    rst        = 1'b0;
    mult_res_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_acc_res", 32'(acc_res), 32'h0);
    check("mid_rst_busy",    32'(busy),    32'h0);
    repeat (4) drive(1'b0, 1'b0, '0);
    check("mid_rst_no_out", 32'(got_q.size()), 32'(0));
    drive(1'b1, 1'b0, '0);
    beats(TOTAL, all_100, 0);
    wait_idle("t_rst");
    expect_pair("t_rst", {1'b0, 16'h6400}, {1'b0, 16'h6400});

    // Beat with start is dropped, restart mid-RUN discards the partial sum,
    // and beats past the final count are ignored.
    drive(1'b1, 1'b1, all_7fff);
    beats(3, all_7fff, 0);
    drive(1'b1, 1'b0, '0);
    beats(TOTAL, all_100, 0);
    beats(5, all_7fff, 0);
    wait_idle("t_restart");
    expect_pair("t_restart", {1'b0, 16'h6400}, {1'b0, 16'h6400});

    repeat (3) drive(1'b0, 1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv1_layer1_dense_accum.md
Name: conv1_layer1_dense_accum

Overview:
Downstream stage of the conv1 layer1 dense multiply array. Takes the 25-lane product vector (25 x 16-bit signed fixed-point, 8 fractional bits) and reduces it to one scalar per beat with a pipelined adder tree. Accumulates ACC_LEN beats per output element and emits a saturated 16-bit result. Runs for N_GROUP outputs per start and then signals done to the layer controller.

Parameters:
N_LANE, 25, product lanes per beat (fixed by the multiply array width of 400 bits)
DW, 16, lane and output width, signed two's complement
ACC_LEN, 4, beats accumulated per output element (1..16)
N_GROUP, 8, output elements per start (1..255)
ACC_W, 32, internal accumulator width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a new run
mult_res_v  in  1  product vector valid, one-cycle pulse per beat; may be asserted every cycle
mult_res  in  400  lane i at bits [16i+15:16i], signed
acc_res  out  16  saturated accumulated sum
acc_res_v  out  1  one-cycle pulse; acc_res valid
sat  out  1  high with acc_res_v when the result was clipped
busy  out  1  high from start until done
done  out  1  one-cycle pulse after the last acc_res_v

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE. acc_res=0, acc_res_v=0, sat=0, busy=0, done=0. Accumulator, beat counter, group counter and all pipeline valid bits cleared. Reset mid-run aborts the run; no further outputs.
- States:
  - IDLE: start -> RUN.
  - RUN: accepts beats. After beat ACC_LEN*N_GROUP is accepted -> DRAIN.
  - DRAIN: waits for the final acc_res_v, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start in any non-IDLE state restarts the run: counters, accumulator and pipeline valids cleared, state -> RUN. Nothing from the old run is output afterwards.
- A beat is accepted only when mult_res_v=1 and state==RUN. A beat arriving in the same cycle as start is dropped. mult_res_v in IDLE/DRAIN/DONE is ignored.
- Pipeline, with a beat accepted at cycle T:
  - T+1: stage 1 registers 5 partial sums of 5 lanes each. Sign-extended to 19 bits.
  - T+2: stage 2 registers the 5-to-1 sum. 21 bits, sign-extended into ACC_W.
  - T+3: accumulator adds the stage-2 sum.
- Every stage carries a valid bit. Gaps between beats are allowed; no stall or backpressure exists.
- Beat counter counts beats at stage 2, from 0 to ACC_LEN-1. On the ACC_LEN-th beat of a group:
  - at T+3: acc_res = sat16(acc + tree_sum), acc_res_v=1, sat set accordingly;
  - the accumulator loads 0, so the next group's first beat starts clean even when back-to-back;
  - the group counter increments.
- sat16: clip to [-32768, 32767], i.e. 0x8000..0x7FFF. sat=1 iff clipped. The internal sum never wraps: ACC_W=32 covers 25*ACC_LEN*2^15.
- acc_res holds its value between pulses. acc_res_v, sat and done are one-cycle pulses.
- busy=1 in RUN, DRAIN and DONE.
- Minimum start-to-done time with beats on consecutive cycles: beats arrive 1..ACC_LEN*N_GROUP cycles after start, the last acc_res_v comes 3 cycles after the last beat, and done follows 1 cycle later.

Decomposition:
- Package conv1_layer1_pkg:
  - constants N_LANE=25, DW=16, FRAC=8;
  - state encoding IDLE/RUN/DRAIN/DONE;
  - sat16 function.
- One sub-module, conv1_layer1_add_tree: 25 x 16-bit in, registered two-stage reduction to 21-bit out with valid passthrough, 2-cycle latency.
- Accumulator, counters and FSM stay in the top module.

Test Plan:
- All lanes 0x0100, 4 consecutive beats, ACC_LEN=4, N_GROUP=1: acc_res=0x6400, sat=0, acc_res_v 3 cycles after the 4th beat, done one cycle later.
- Lane 0=0x0005, other lanes 0, beats with 2-cycle gaps, N_GROUP=2: two acc_res_v pulses, each 0x0014, accumulator clean between groups.
- All lanes 0x7FFF for 4 beats -> acc_res=0x7FFF, sat=1. All lanes 0x8000 for 4 beats -> acc_res=0x8000, sat=1.
- Lane 0=0xFFFF, lane 1=0x0001, others 0x0000 -> per-beat sum 0, acc_res=0x0000. Mixed signs: lane 0=0x0100, lane 1=0xFF00 plus lane 2=0x0003 -> acc_res=0x000C.
- rst=0 for one cycle after 2 beats of a group, then start and 4 beats of 0x0100 -> only one acc_res_v, value 0x6400. busy and done track the new run only.
- mult_res_v in IDLE and DRAIN, and beats after the final count -> ignored, no extra acc_res_v. start mid-RUN -> old partial sum discarded.
